piano_key_scheduler: RTL and testbench

Event scheduler between the per-key debouncers and the tone generator of the FPGA piano. Watches the N debounced key levels, turns press (and optionally release) edges into an ordered event stream over a valid/ready handshake, buffered in a small FIFO. Also tracks the currently sounding key for monophonic playback.

---
 rtl/piano_key_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_piano_key_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_key_scheduler.sv
// piano_key_scheduler: turns debounced key edges into an ordered event stream
// (valid/ready, small FIFO) and tracks the currently sounding key for
// monophonic playback.
// Optional build macro KEY_RELEASE_EVT_EN: also queue release events
// (EVT_PRESS = 0). Without it only presses are queued and EVT_PRESS mirrors
// EVT_VALID.
module piano_key_scheduler #(
  parameter  int N_KEYS     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int IW         = $clog2(N_KEYS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEYS,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [IW-1:0]     EVT_KEY,
  output logic              EVT_PRESS,
  output logic              ACTIVE_VALID,
  output logic [IW-1:0]     ACTIVE_KEY,
  output logic              OVERFLOW
);

  localparam int                PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]       CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [N_KEYS-1:0] ONE_HOT0 = N_KEYS'(1);

  logic [N_KEYS-1:0] r_key_prev;
  logic [N_KEYS-1:0] r_press_pend;
  logic [IW-1:0]     r_fifo_key [FIFO_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW:0]       r_count;
  logic              r_active_valid;
  logic [IW-1:0]     r_active_key;
  logic              r_overflow;

  logic [N_KEYS-1:0] w_rise;
  logic [N_KEYS-1:0] w_fall;
  logic              w_pop;
  logic              w_space;
  logic              w_push;
  logic [IW-1:0]     w_push_idx;
  logic              w_press_any;
  logic [IW-1:0]     w_press_idx;
  logic              w_rel_any;
  logic [IW-1:0]     w_rel_idx;
  logic [N_KEYS-1:0] w_clr_press;
  logic              w_merge;
  logic              w_rise_any;
  logic [IW-1:0]     w_rise_hi_idx;
  logic              w_keys_any;
  logic [IW-1:0]     w_keys_lo_idx;
  logic              w_active_fall;

  assign w_rise  = KEYS & ~r_key_prev;
  assign w_fall  = ~KEYS & r_key_prev;
  assign w_pop   = (r_count != '0) & EVT_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_space = (r_count != CNT_FULL) | w_pop;

  // Lowest-index pending press is the first push candidate.
  always_comb begin
    w_press_any = 1'b0;
    w_press_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (r_press_pend[i]) begin
        w_press_any = 1'b1;
        w_press_idx = IW'(i);
      end
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  logic [N_KEYS-1:0] r_rel_pend;
  logic              r_fifo_press [FIFO_DEPTH];
  logic [N_KEYS-1:0] w_clr_rel;

  // Lowest-index pending release, used only when no press is pending.
  always_comb begin
    w_rel_any = 1'b0;
    w_rel_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (r_rel_pend[i]) begin
        w_rel_any = 1'b1;
        w_rel_idx = IW'(i);
      end
    end
  end

  assign w_clr_rel = (w_push & ~w_press_any) ? (ONE_HOT0 << w_rel_idx) : '0;
  assign w_merge   = |(w_rise & r_press_pend & ~w_clr_press) |
                     |(w_fall & r_rel_pend & ~w_clr_rel);
  assign EVT_PRESS = EVT_VALID & r_fifo_press[r_rd_ptr];

  // Release pending set: falls accumulate until scheduled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rel_pend <= '0;
    end else begin
      r_rel_pend <= (r_rel_pend & ~w_clr_rel) | w_fall;
    end
  end

  // Event type storage alongside the key index.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_press[r_wr_ptr] <= w_press_any;
    end
  end
`else
  assign w_rel_any = 1'b0;
  assign w_rel_idx = '0;
  assign w_merge   = |(w_rise & r_press_pend & ~w_clr_press);
  assign EVT_PRESS = EVT_VALID;
`endif

  assign w_push      = w_space & (w_press_any | w_rel_any);
  assign w_push_idx  = w_press_any ? w_press_idx : w_rel_idx;
  assign w_clr_press = (w_push & w_press_any) ? (ONE_HOT0 << w_press_idx) : '0;

  // Highest-index rising key and lowest-index held key for active tracking.
  always_comb begin
    w_rise_any    = 1'b0;
    w_rise_hi_idx = '0;
    w_keys_any    = 1'b0;
    w_keys_lo_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (w_rise[i]) begin
        w_rise_any    = 1'b1;
        w_rise_hi_idx = IW'(i);
      end
    end
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (KEYS[i]) begin
        w_keys_any    = 1'b1;
        w_keys_lo_idx = IW'(i);
      end
    end
  end

  assign w_active_fall = r_active_valid & w_fall[r_active_key];

  // Edge history, press pending set and sticky merge flag. A bit cleared by
  // a push and re-set by a new edge in the same cycle ends set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key_prev   <= '0;
      r_press_pend <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_key_prev   <= KEYS;
      r_press_pend <= (r_press_pend & ~w_clr_press) | w_rise;
      if (w_merge) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO key storage; contents are don't-care while the slot is empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_key[r_wr_ptr] <= w_push_idx;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Monophonic selection: newest press wins; losing the sounding key falls
  // back to the lowest key still held.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_active_valid <= 1'b0;
      r_active_key   <= '0;
    end else if (w_rise_any) begin
      r_active_valid <= 1'b1;
      r_active_key   <= w_rise_hi_idx;
    end else if (w_active_fall) begin
      r_active_valid <= w_keys_any;
      r_active_key   <= w_keys_lo_idx;
    end
  end

  assign EVT_VALID    = (r_count != '0);
  assign EVT_KEY      = EVT_VALID ? r_fifo_key[r_rd_ptr] : '0;
  assign ACTIVE_VALID = r_active_valid;
  assign ACTIVE_KEY   = r_active_key;
  assign OVERFLOW     = r_overflow;

endmodule

// File: tb/tb_piano_key_scheduler.sv
// Testbench for piano_key_scheduler: directed scenarios plus random key and
// backpressure traffic, scored against a queue-based reference model.
module tb_piano_key_scheduler;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int IW = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [N-1:0]  KEYS = '0;
  logic          EVT_READY = 1'b0;
  logic          EVT_VALID;
  logic [IW-1:0] EVT_KEY;
  logic          EVT_PRESS;
  logic          ACTIVE_VALID;
  logic [IW-1:0] ACTIVE_KEY;
  logic          OVERFLOW;

  piano_key_scheduler #(.N_KEYS(N), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET), .KEYS(KEYS),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_KEY(EVT_KEY),
    .EVT_PRESS(EVT_PRESS), .ACTIVE_VALID(ACTIVE_VALID),
    .ACTIVE_KEY(ACTIVE_KEY), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int key;
    bit press;
  } evt_t;

  // Reference model state: set of pending keys, FIFO occupancy, expected
  // event order, monophonic choice and sticky merge flag.
  evt_t exp_q[$];
  bit   m_prev [N];
  bit   m_pp   [N];
  bit   m_rp   [N];
  int   m_cnt = 0;
  bit   m_av  = 0;
  int   m_ak  = 0;
  bit   m_ovf = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < N; k++) if (m_pp[k] || m_rp[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit pop;
    bit space;
    bit push;
    bit cpress;
    int cand;
    int hi;
    evt_t e;
    if (RESET) begin
      for (int k = 0; k < N; k++) begin
        m_prev[k] = 0; m_pp[k] = 0; m_rp[k] = 0;
      end
      m_cnt = 0; m_av = 0; m_ak = 0; m_ovf = 0;
      exp_q.delete();
      return;
    end
    pop   = (m_cnt != 0) && EVT_READY;
    space = (m_cnt < D) || pop;
    cand  = -1;
    cpress = 1'b0;
    for (int k = 0; k < N; k++) if (m_pp[k]) begin cand = k; cpress = 1'b1; break; end
    if (cand < 0)
      for (int k = 0; k < N; k++) if (m_rp[k]) begin cand = k; cpress = 1'b0; break; end
    push = space && (cand >= 0);
    if (push) begin
      e.key = cand;
      e.press = cpress;
      exp_q.push_back(e);
      if (cpress) m_pp[cand] = 0; else m_rp[cand] = 0;
    end
    m_cnt = m_cnt + int'(push) - int'(pop);
    hi = -1;
    for (int k = 0; k < N; k++) begin
      if (KEYS[k] && !m_prev[k]) begin
        if (m_pp[k]) m_ovf = 1'b1;
        m_pp[k] = 1'b1;
        hi = k;
      end
`ifdef KEY_RELEASE_EVT_EN
      if (!KEYS[k] && m_prev[k]) begin
        if (m_rp[k]) m_ovf = 1'b1;
        m_rp[k] = 1'b1;
      end
`endif
    end
    if (hi >= 0) begin
      m_av = 1'b1;
      m_ak = hi;
    end else if (m_av && !KEYS[m_ak] && m_prev[m_ak]) begin
      m_av = 1'b0;
      m_ak = 0;
      for (int k = N - 1; k >= 0; k--) if (KEYS[k]) begin m_av = 1'b1; m_ak = k; end
    end
    for (int k = 0; k < N; k++) m_prev[k] = KEYS[k];
  endtask

  // Model advances on every active edge, using the inputs the DUT samples.
  initial begin
    forever begin
      @(posedge CLK);
      model_step();
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      chk("evt_valid", int'(EVT_VALID), int'(m_cnt != 0));
      if (EVT_VALID) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL evt_unexpected: key %0d press %0d presented, none expected at t=%0t",
                   EVT_KEY, EVT_PRESS, $time);
        end else begin
          chk("evt_key", int'(EVT_KEY), exp_q[0].key);
          chk("evt_press", int'(EVT_PRESS), int'(exp_q[0].press));
          if (EVT_READY) void'(exp_q.pop_front());
        end
      end else begin
        chk("evt_press_idle", int'(EVT_PRESS), 0);
      end
      chk("active_valid", int'(ACTIVE_VALID), int'(m_av));
      chk("active_key", int'(ACTIVE_KEY), m_ak);
      chk("overflow", int'(OVERFLOW), int'(m_ovf));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    EVT_READY = 1'b1;
    while ((exp_q.size() != 0 || m_cnt != 0 || any_pending()) && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("drain_left", exp_q.size() + m_cnt, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
  endtask

  initial begin
    int b;
    tick(3);
    RESET = 1'b0;
    chk("rst_evt_valid", int'(EVT_VALID), 0);
    chk("rst_evt_key", int'(EVT_KEY), 0);
    chk("rst_evt_press", int'(EVT_PRESS), 0);
    chk("rst_active_valid", int'(ACTIVE_VALID), 0);
    chk("rst_active_key", int'(ACTIVE_KEY), 0);
    chk("rst_overflow", int'(OVERFLOW), 0);

    // Single press: active after 1 cycle, event after 2.
    EVT_READY = 1'b1;
    KEYS = 8'h08;
    tick(1);
    chk("s1_active_key", int'(ACTIVE_KEY), 3);
    chk("s1_active_valid", int'(ACTIVE_VALID), 1);
    chk("s1_valid_early", int'(EVT_VALID), 0);
    tick(1);
    chk("s1_valid", int'(EVT_VALID), 1);
    chk("s1_key", int'(EVT_KEY), 3);
    chk("s1_press", int'(EVT_PRESS), 1);
    KEYS = '0;
    tick(2);
    drain();

    // Simultaneous presses under backpressure drain in index order.
    EVT_READY = 1'b0;
    KEYS = 8'h25;
    tick(10);
    chk("s2_active_key", int'(ACTIVE_KEY), 5);
    chk("s2_head_key", int'(EVT_KEY), 0);
    EVT_READY = 1'b1;
    tick(6);
    KEYS = '0;
    tick(1);
    drain();

    // Six presses into a four-entry FIFO: two wait pending, none lost.
    EVT_READY = 1'b0;
    for (int k = 0; k < 6; k++) begin
      KEYS[k] = 1'b1;
      tick(1);
    end
    tick(3);
    chk("s3_head_key", int'(EVT_KEY), 0);
    EVT_READY = 1'b1;
    tick(10);
    chk("s3_overflow", int'(OVERFLOW), 0);
    KEYS = '0;
    tick(1);
    drain();

    // Re-press of a key whose press is still pending merges and flags.
    EVT_READY = 1'b0;
    for (int k = 4; k < 8; k++) begin
      KEYS[k] = 1'b1;
      tick(1);
    end
    tick(1);
    KEYS[1] = 1'b1; tick(1);
    KEYS[1] = 1'b0; tick(1);
    KEYS[1] = 1'b1; tick(1);
    chk("s4_overflow", int'(OVERFLOW), 1);
    drain();
    KEYS = '0;
    tick(1);
    drain();
    chk("s4_overflow_sticky", int'(OVERFLOW), 1);
    do_reset();
    chk("s4_overflow_cleared", int'(OVERFLOW), 0);

    // Monophonic fallback to the lowest held key.
    EVT_READY = 1'b1;
    KEYS = 8'h04; tick(1);
    KEYS = 8'h44; tick(1);
    chk("s5_active_6", int'(ACTIVE_KEY), 6);
    KEYS = 8'h04; tick(1);
    chk("s5_active_2", int'(ACTIVE_KEY), 2);
    chk("s5_active_valid", int'(ACTIVE_VALID), 1);
    KEYS = 8'h00; tick(1);
    chk("s5_active_none", int'(ACTIVE_VALID), 0);
    drain();

    // Random keys, backpressure and occasional mid-stream reset.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, N - 1);
        KEYS[b] = ~KEYS[b];
      end
      if ($urandom_range(0, 39) == 0) KEYS = N'($urandom);
      EVT_READY = ($urandom_range(0, 2) != 0);
      RESET = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    RESET = 1'b0;
    drain();

    // Reset mid-stream with a key held: queue dropped, held key re-reported.
    EVT_READY = 1'b0;
    KEYS = 8'h00;
    tick(1);
    KEYS = 8'hF0;
    tick(6);
    chk("s6_full_valid", int'(EVT_VALID), 1);
    KEYS = 8'h01;
    RESET = 1'b1;
    tick(1);
    chk("s6_rst_valid", int'(EVT_VALID), 0);
    RESET = 1'b0;
    tick(1);
    chk("s6_pending_valid", int'(EVT_VALID), 0);
    tick(1);
    chk("s6_valid", int'(EVT_VALID), 1);
    chk("s6_key", int'(EVT_KEY), 0);
    chk("s6_press", int'(EVT_PRESS), 1);
    drain();
    KEYS = '0;
    tick(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
